// File: rtl/ex_div_if.sv
// ex_div_if: EX-stage divider request/operand bus and result/stall return
interface ex_div_if #(parameter int DATA_W = 32);
    logic start, annul, signed_div;
    logic [DATA_W-1:0] opdata1, opdata2;
    logic [5:0] stall;
    logic [2*DATA_W-1:0] result;
    logic ready, stallreq;
    modport master(output start, annul, signed_div, opdata1, opdata2, stall, input result, ready, stallreq);
    modport slave(input start, annul, signed_div, opdata1, opdata2, stall, output result, ready, stallreq);
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for MIPS DIV/DIVU in EX
// One quotient bit per cycle on absolute values; signs are applied on the final iteration.
module ex_div #(parameter int DATA_W = 32) (
    input logic clk,
    input logic rst,
    ex_div_if.slave d
);
    typedef enum logic [1:0] {FREE, BUSY, DONE} state_t;
    localparam int CW = $clog2(DATA_W + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] rem, dvd, dvs, rem_nx, dvd_nx, q_nx, r_nx;
    logic [DATA_W:0] sh, diff;
    logic qneg, rneg, accept, last;
    assign accept = state == FREE && d.start && !d.annul;
    assign last = cnt == CW'(DATA_W - 1);
    // dvd shifts out dividend bits at the top while quotient bits enter at the bottom
    assign sh = {rem, dvd[DATA_W-1]};
    assign diff = sh - {1'b0, dvs};
    assign rem_nx = diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
    assign dvd_nx = {dvd[DATA_W-2:0], ~diff[DATA_W]};
    assign q_nx = qneg ? -dvd_nx : dvd_nx;
    assign r_nx = rneg ? -rem_nx : rem_nx;
    always_ff @(posedge clk)
        state <= rst ? FREE : state_nx;
    always_comb
        state_nx = d.annul ? FREE :
                   state == FREE ? (d.start ? (d.opdata2 == '0 ? DONE : BUSY) : FREE) :
                   state == BUSY ? (last ? DONE : BUSY) :
                   d.stall[3] ? DONE : FREE;
    always_comb begin
        d.ready = state == DONE;
        d.stallreq = accept || state == BUSY;
    end
    always_ff @(posedge clk)
        if (rst) begin
            cnt <= '0;
            rem <= '0;
            dvd <= '0;
            dvs <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
            d.result <= '0;
        end else if (accept) begin
            cnt <= '0;
            rem <= '0;
            dvd <= d.signed_div && d.opdata1[DATA_W-1] ? -d.opdata1 : d.opdata1;
            dvs <= d.signed_div && d.opdata2[DATA_W-1] ? -d.opdata2 : d.opdata2;
            qneg <= d.signed_div && (d.opdata1[DATA_W-1] ^ d.opdata2[DATA_W-1]);
            rneg <= d.signed_div && d.opdata1[DATA_W-1];
            if (d.opdata2 == '0) d.result <= '0;
        end else if (state == BUSY && !d.annul) begin
            cnt <= cnt + 1'b1;
            rem <= rem_nx;
            dvd <= dvd_nx;
            if (last) d.result <= {r_nx, q_nx};
        end
endmodule
